// File: rtl/fifo_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkt_pkg
//  Description : Shared definitions for the FIFO packet writer: FSM state
//                encoding, sequence-number width, packet-count width and
//                header field placement.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkt_pkg;

  // Writer FSM states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    TRAILER = 2'd3
  } pkt_state_e;

  // Width of the per-packet sequence number carried in the header.
  localparam int SEQ_WIDTH = 8;

  // Width of the saturating completed-packet counter.
  localparam int PKT_COUNT_WIDTH = 16;

  // Header layout (LSB first): length field at bit 0, sequence number
  // directly above it, remaining upper bits zero.
  localparam int HDR_LEN_LSB = 0;

  // The sequence field starts right above the length field, so its
  // position depends on the configured length width.
  function automatic int hdr_seq_lsb(input int len_width);
    return HDR_LEN_LSB + len_width;
  endfunction

endpackage : fifo_pkt_pkg
`default_nettype wire

// File: rtl/fifo_pkt_writer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkt_writer
//  Description : Frames payload words into packets written to a FIFO:
//                header {seq, len}, len payload words passed straight
//                through, then an XOR checksum trailer. Stalls on full
//                without losing or repeating words.
//  Revision    : 1.0  initial release
//
//  Ports
//    wr_clk     in   write-domain clock
//    wr_rst_n   in   asynchronous active-low reset
//    req_valid  in   packet request valid
//    req_ready  out  request accepted when req_valid && req_ready
//    req_len    in   payload word count for the request
//    s_valid    in   payload word valid
//    s_ready    out  payload word accepted when s_valid && s_ready
//    s_data     in   payload word
//    wr_en      out  FIFO write strobe (never asserted while full)
//    wr_data    out  FIFO write word
//    full       in   FIFO full flag, wr_clk domain
//    busy       out  high whenever a packet is in progress
//    pkt_count  out  completed packets, saturates at all-ones
//
//  DATA_WIDTH must be at least LEN_WIDTH + SEQ_WIDTH so the header fits.
// ============================================================================
module fifo_pkt_writer
  import fifo_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                       wr_clk,
  input  logic                       wr_rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [LEN_WIDTH-1:0]       req_len,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_WIDTH-1:0]      s_data,
  output logic                       wr_en,
  output logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       full,
  output logic                       busy,
  output logic [PKT_COUNT_WIDTH-1:0] pkt_count
);

  localparam int SEQ_LSB = hdr_seq_lsb(LEN_WIDTH);

  pkt_state_e                 state_q,     state_d;
  logic [SEQ_WIDTH-1:0]       seq_q,       seq_d;
  logic [LEN_WIDTH-1:0]       len_q,       len_d;
  logic [LEN_WIDTH-1:0]       cnt_q,       cnt_d;
  logic [DATA_WIDTH-1:0]      csum_q,      csum_d;
  logic [PKT_COUNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

  logic [DATA_WIDTH-1:0]      hdr_word;
  logic [LEN_WIDTH-1:0]       cnt_inc;

  // Header built from registered fields only, so it holds steady across
  // any full stall.
  always_comb begin
    hdr_word                              = '0;
    hdr_word[HDR_LEN_LSB +: LEN_WIDTH]    = len_q;
    hdr_word[SEQ_LSB +: SEQ_WIDTH]        = seq_q;
  end

  assign cnt_inc = cnt_q + LEN_WIDTH'(1);

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    pkt_count_d = pkt_count_q;

    req_ready   = 1'b0;
    s_ready     = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;

    case (state_q)
      IDLE: begin
        // Gated by reset so req_ready is low for the whole reset window,
        // even though the state register already reads IDLE.
        req_ready = wr_rst_n;
        if (req_valid) begin
          len_d   = req_len;
          csum_d  = '0;
          cnt_d   = '0;
          state_d = HEADER;
        end
      end

      HEADER: begin
        wr_data = hdr_word;
        wr_en   = !full;
        if (!full) begin
          state_d = (len_q != '0) ? PAYLOAD : TRAILER;
        end
      end

      PAYLOAD: begin
        // Zero-latency pass-through: the FIFO sees s_data in the same cycle
        // it is accepted, and full back-pressures the source directly.
        s_ready = !full;
        wr_en   = s_valid && !full;
        wr_data = s_data;
        if (s_valid && !full) begin
          csum_d = csum_q ^ s_data;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = TRAILER;
          end
        end
      end

      TRAILER: begin
        wr_data = csum_q;
        wr_en   = !full;
        if (!full) begin
          seq_d = seq_q + SEQ_WIDTH'(1);
          if (pkt_count_q != '1) begin
            pkt_count_d = pkt_count_q + PKT_COUNT_WIDTH'(1);
          end
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q     <= IDLE;
      seq_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign pkt_count = pkt_count_q;

endmodule : fifo_pkt_writer
`default_nettype wire
